// File: rtl/serial_uart_bridge.sv
// Byte-wide serial channel to 8N1 UART bridge: CPU writes become TX frames,
// received frames become a single-entry RX buffer with valid/overrun/frame-error flags.
module serial_uart_bridge #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cpu_wdata,
    input  logic       cpu_wren,
    input  logic       cpu_rden,
    output logic [7:0] cpu_rdata,
    output logic       cpu_valid,
    output logic       cpu_ready,
    output logic       uart_tx,
    input  logic       uart_rx,
    output logic       rx_overrun,
    output logic       rx_frame_err
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // ---------------- TX ----------------
    logic [1:0]    tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_line_q, tx_line_d;
    logic          tx_ready_q, tx_ready_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        tx_ready_d = tx_ready_q;
        case (tx_state_q)
            ST_IDLE: begin
                if (cpu_wren) begin
                    tx_state_d = ST_START;
                    tx_cnt_d   = '0;
                    tx_shift_d = cpu_wdata;
                    tx_line_d  = 1'b0;
                    tx_ready_d = 1'b0;
                end
            end
            ST_START: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_state_d = ST_DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = 3'd0;
                    tx_line_d  = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = ST_STOP;
                        tx_line_d  = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_line_d  = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: begin
                // Ready rises together with the return to IDLE so a write in the
                // first IDLE cycle starts the next frame without an idle bit.
                if (tx_cnt_q == CNT_LAST) begin
                    tx_state_d = ST_IDLE;
                    tx_cnt_d   = '0;
                    tx_ready_d = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            tx_line_q  <= 1'b1;
            tx_ready_q <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    // ---------------- RX ----------------
    logic          rx_s1_q, rx_s2_q;
    logic [1:0]    rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_done_q, rx_done_d;
    logic          rx_ferr_q, rx_ferr_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done_d  = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                if (!rx_s2_q) begin
                    rx_state_d = ST_START;
                    rx_cnt_d   = '0;
                end
            end
            ST_START: begin
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = ST_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_IDLE;
                    rx_done_d  = rx_s2_q;
                    rx_ferr_d  = ~rx_s2_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
        endcase
    end

    // A read on the completion edge consumes the old byte, so no overrun.
    always_comb begin
        rdata_d   = rdata_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (rx_done_q) begin
            rdata_d = rx_shift_q;
            valid_d = 1'b1;
            if (valid_q && !cpu_rden) begin
                overrun_d = 1'b1;
            end
        end else if (cpu_rden) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_done_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rdata_q    <= 8'h00;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rx_s1_q    <= uart_rx;
            rx_s2_q    <= rx_s1_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_done_q  <= rx_done_d;
            rx_ferr_q  <= rx_ferr_d;
            rdata_q    <= rdata_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign uart_tx      = tx_line_q;
    assign cpu_ready    = tx_ready_q;
    assign cpu_rdata    = rdata_q;
    assign cpu_valid    = valid_q;
    assign rx_overrun   = overrun_q;
    assign rx_frame_err = rx_ferr_q;

endmodule

// File: tb/tb_serial_uart_bridge.sv
// Directed + randomized bench for serial_uart_bridge; expected frames and RX buffer
// state come from a frame-level model of the UART and the single-entry buffer.
module tb_serial_uart_bridge;

    localparam int unsigned CPB = 4;

    logic       clk;
    logic       rst;
    logic [7:0] cpu_wdata;
    logic       cpu_wren;
    logic       cpu_rden;
    logic [7:0] cpu_rdata;
    logic       cpu_valid;
    logic       cpu_ready;
    logic       uart_tx;
    logic       uart_rx;
    logic       rx_overrun;
    logic       rx_frame_err;

    logic       rx_drv;
    logic       loop_en;

    int n_checks;
    int n_errors;
    int fe_cnt;
    int fe_base;

    // Behavioural RX buffer model
    logic [7:0] m_rdata;
    logic       m_valid;
    logic       m_overrun;
    logic [7:0] exp_q[$];

    assign uart_rx = loop_en ? uart_tx : rx_drv;

    serial_uart_bridge #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_wdata   (cpu_wdata),
        .cpu_wren    (cpu_wren),
        .cpu_rden    (cpu_rden),
        .cpu_rdata   (cpu_rdata),
        .cpu_valid   (cpu_valid),
        .cpu_ready   (cpu_ready),
        .uart_tx     (uart_tx),
        .uart_rx     (uart_rx),
        .rx_overrun  (rx_overrun),
        .rx_frame_err(rx_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial fe_cnt = 0;
    always @(negedge clk) begin
        if (rx_frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_buffer(input string tag);
        chk({tag, "_valid"}, {31'd0, cpu_valid}, {31'd0, m_valid});
        chk({tag, "_rdata"}, {24'd0, cpu_rdata}, {24'd0, m_rdata});
        chk({tag, "_overrun"}, {31'd0, rx_overrun}, {31'd0, m_overrun});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_ready", {31'd0, cpu_ready}, 32'd1);
        chk("rst_valid", {31'd0, cpu_valid}, 32'd0);
        chk("rst_rdata", {24'd0, cpu_rdata}, 32'd0);
        chk("rst_overrun", {31'd0, rx_overrun}, 32'd0);
        chk("rst_ferr", {31'd0, rx_frame_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_rdata = 8'h00;
        m_valid = 1'b0;
        m_overrun = 1'b0;
        @(negedge clk);
    endtask

    // Writes one byte and checks the full 8N1 waveform plus ready timing.
    // With poke set, a stray write during the frame must be ignored.
    task automatic tx_write_check(input logic [7:0] d, input bit poke);
        int idx;
        logic expb;
        chk("tx_ready_idle", {31'd0, cpu_ready}, 32'd1);
        cpu_wdata = d;
        cpu_wren = 1'b1;
        @(negedge clk);
        cpu_wren = 1'b0;
        for (int k = 0; k < 10 * CPB; k++) begin
            idx = k / CPB;
            expb = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : d[idx-1];
            chk("tx_line", {31'd0, uart_tx}, {31'd0, expb});
            chk("tx_ready_busy", {31'd0, cpu_ready}, 32'd0);
            if (poke && k == 10) begin
                cpu_wdata = ~d;
                cpu_wren = 1'b1;
            end else begin
                cpu_wdata = d;
                cpu_wren = 1'b0;
            end
            @(negedge clk);
        end
        chk("tx_ready_after", {31'd0, cpu_ready}, 32'd1);
        chk("tx_line_idle", {31'd0, uart_tx}, 32'd1);
    endtask

    // Drives one frame on rx_drv; returns 40 cycles later with the line idle.
    task automatic rx_send(input logic [7:0] d, input logic stop);
        for (int b = 0; b < 10; b++) begin
            rx_drv = (b == 0) ? 1'b0 : (b == 9) ? stop : d[b-1];
            repeat (CPB) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (cpu_valid === 1'b1) break;
            @(negedge clk);
        end
        chk(tag, {31'd0, cpu_valid}, 32'd1);
    endtask

    task automatic read_byte();
        cpu_rden = 1'b1;
        @(negedge clk);
        cpu_rden = 1'b0;
        m_valid = 1'b0;
        chk("read_clears_valid", {31'd0, cpu_valid}, 32'd0);
    endtask

    // Transmits every byte in exp_q back-to-back over the loopback while a
    // reader consumes each received byte in order.
    task automatic loopback_run();
        int n;
        n = exp_q.size();
        fork
            begin
                for (int i = 0; i < n; i++) tx_write_check(exp_q[i], 1'b0);
            end
            begin
                for (int j = 0; j < n; j++) begin
                    wait_valid("lb_valid");
                    chk("lb_rdata", {24'd0, cpu_rdata}, {24'd0, exp_q[j]});
                    m_rdata = exp_q[j];
                    read_byte();
                end
            end
        join
        chk_buffer("lb_end");
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] d6;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        cpu_wdata = 8'h00;
        cpu_wren = 1'b0;
        cpu_rden = 1'b0;
        rx_drv = 1'b1;
        loop_en = 1'b0;
        m_rdata = 8'h00;
        m_valid = 1'b0;
        m_overrun = 1'b0;
        #1;
        do_reset();
        chk_buffer("post_reset");

        // TX frame for 0xA5 with an ignored mid-frame write
        tx_write_check(8'hA5, 1'b1);

        // Loopback: 0x3C, 0xC3 back-to-back, then random bytes
        fe_base = fe_cnt;
        loop_en = 1'b1;
        exp_q = '{8'h3C, 8'hC3};
        loopback_run();
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(8'($urandom));
        loopback_run();
        loop_en = 1'b0;
        chk("lb_no_ferr", fe_cnt - fe_base, 32'd0);

        // One-cycle glitch must not start a byte
        fe_base = fe_cnt;
        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (30) @(negedge clk);
        chk_buffer("glitch");
        chk("glitch_no_ferr", fe_cnt - fe_base, 32'd0);
        r = 8'($urandom);
        rx_send(r, 1'b1);
        repeat (4) @(negedge clk);
        m_rdata = r;
        m_valid = 1'b1;
        chk_buffer("after_glitch");
        read_byte();

        // Framing error: stop bit low
        fe_base = fe_cnt;
        rx_send(8'h55, 1'b0);
        repeat (8) @(negedge clk);
        chk("ferr_pulse_count", fe_cnt - fe_base, 32'd1);
        chk_buffer("ferr");

        // Overrun without read
        rx_send(8'h11, 1'b1);
        repeat (4) @(negedge clk);
        m_rdata = 8'h11;
        m_valid = 1'b1;
        chk_buffer("ovr_first");
        rx_send(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        m_rdata = 8'h22;
        m_overrun = 1'b1;
        chk_buffer("ovr_second");

        // Read coincident with completion: no overrun
        do_reset();
        rx_send(8'h11, 1'b1);
        repeat (4) @(negedge clk);
        rx_send(8'h22, 1'b1);
        @(negedge clk);
        cpu_rden = 1'b1;
        @(negedge clk);
        cpu_rden = 1'b0;
        m_rdata = 8'h22;
        m_valid = 1'b1;
        chk_buffer("rd_on_complete");

        // Reset mid TX (data bit 3) and mid RX frame
        d6 = 8'h96;
        cpu_wdata = d6;
        cpu_wren = 1'b1;
        rx_drv = 1'b0;
        @(negedge clk);
        cpu_wren = 1'b0;
        repeat (17) @(negedge clk);
        chk("tx_mid_bit3", {31'd0, uart_tx}, {31'd0, d6[3]});
        rx_drv = 1'b1;
        do_reset();
        tx_write_check(8'h01, 1'b0);
        repeat (40) @(negedge clk);
        chk_buffer("post_mid_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
